serial_adder_subtractor: RTL and testbench
==========================================

// Module: serial_adder_subtractor
// PURPOSE
//   Bit-serial adder/subtractor: accepts a word pair with a valid/ready handshake and processes one bit per
//   clock, LSB first, through a single full adder. Holds the result until the consumer takes it.
//   It is the sequential, area-minimal counterpart of the parallel adders in this codebase.
//   Its S/CF/OF results are bit-exact with the ripple_carry_adder for SUB=0.
// PARAMETERS
//   DATA_WIDTH   4   operand/result width in bits; must be >= 2
// PORTS
//   CLK        in   1           single clock, rising edge
//   RST        in   1           asynchronous, active-high reset
//   in_valid   in   1           operand word valid
//   in_ready   out  1           block can accept operands
//   A          in   DATA_WIDTH  operand A (two's complement or unsigned)
//   B          in   DATA_WIDTH  operand B
//   Cin        in   1           carry-in; used only when SUB=0
//   SUB        in   1           0: S=A+B+Cin; 1: S=A-B (B inverted, carry-in forced 1, Cin ignored)
//   out_valid  out  1           result valid
//   out_ready  in   1           consumer accepts result
//   S          out  DATA_WIDTH  sum/difference
//   CF         out  1           raw carry out of MSB (for SUB=1, CF=1 means no borrow)
//   OF         out  1           signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, S=0, CF=0, OF=0, bit counter=0, carry=0.
//   - FSM states and transitions:
//     - IDLE: in_ready=1. On in_valid&in_ready, latch A, B^{DATA_WIDTH{SUB}}, carry=SUB?1:Cin, then go to SHIFT.
//     - SHIFT: in_ready=0. Each cycle, full-add the LSBs of the A/B shift registers with the carry register.
//       Shift the sum bit into the MSB of the S shift register; update carry; increment the counter.
//       After DATA_WIDTH cycles go to DONE. CF=final carry. OF=carry-in of the last bit XOR CF.
//     - DONE: out_valid=1. S, CF and OF stay stable while out_valid=1.
//       On out_ready, go to IDLE: out_valid=0 next cycle, S/CF/OF keep their last values.
//   - Latency: with acceptance at edge t, out_valid rises after edge t+DATA_WIDTH, one cycle in SHIFT per bit.
//     Back-to-back throughput: one result per DATA_WIDTH+2 cycles.
//   - in_ready is asserted only in IDLE. Operands presented in SHIFT/DONE are not sampled.
//     in_valid with out_ready in the same cycle does not overlap operations.
//   - out_ready outside DONE is ignored. Backpressure of any length holds DONE with outputs unchanged.
//   - Arithmetic is modulo 2^DATA_WIDTH. Wrap-around is reported only through CF/OF, never saturated.
//   - Counter width is $clog2(DATA_WIDTH)+1. Terminal compare is count==DATA_WIDTH-1 in SHIFT.
//   - RST during SHIFT or DONE aborts the operation. The result is discarded, not delivered.
//   - No X propagation: operand registers are reset to 0.
// CONFIGURATION
//   SERIAL_ADD_SUB_STATUS_FLAGS_EN
//     defined: adds outputs ZF (1: S==0) and NF (=S[DATA_WIDTH-1]).
//       Both are registered together with CF/OF, reset to 0 and stable in DONE.
//     undefined: ZF/NF ports and their logic do not exist. All other behaviour is identical.
// TESTING  (DATA_WIDTH=4; every result is checked at out_valid rise, and the edge count from accept is checked =DATA_WIDTH)
//   1. SUB=0 A=0001 B=0100 Cin=0 -> S=0101 CF=0 OF=0; out_valid 4 cycles after accept
//   2. SUB=0 A=1101 B=1100 Cin=0 -> S=1001 CF=1 OF=0; SUB=0 A=0101 B=0111 -> S=1100 CF=0 OF=1
//   3. SUB=1 A=1000 B=1011 Cin=1 (ignored) -> S=1101 CF=0 OF=0; SUB=1 A=0111 B=1111 -> S=1000 CF=0 OF=1
//   4. SUB=0 A=1111 B=0000 Cin=1 -> S=0000 CF=1 OF=0; with macro ZF=1 NF=0; without macro no ZF/NF ports
//   5. out_ready low 5 cycles in DONE, new in_valid pulses -> S/CF/OF stable, in_ready=0, no second accept
//   6. RST asserted mid-SHIFT (bit 2) -> out_valid=0, in_ready=1, S=0 immediately; next op 0011+0001 -> S=0100

Source files
------------

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor, LSB first through one full adder, valid/ready on both sides.
// Define SERIAL_ADD_SUB_STATUS_FLAGS_EN to add registered ZF/NF status outputs.
module serial_adder_subtractor #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    input  logic                  SUB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF
`ifdef SERIAL_ADD_SUB_STATUS_FLAGS_EN
    ,
    output logic                  ZF,
    output logic                  NF
`endif
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  carry_q, carry_d;
    logic                  cf_q, cf_d;
    logic                  of_q, of_d;
    logic                  zf_q, zf_d;
    logic                  nf_q, nf_d;

    logic                  sum_bit;
    logic                  carry_out;
    logic [DATA_WIDTH-1:0] s_next;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign s_next    = {sum_bit, s_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        count_d = count_q;
        carry_d = carry_q;
        cf_d    = cf_q;
        of_d    = of_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    // Subtraction is A + ~B + 1.
                    b_d     = B ^ {DATA_WIDTH{SUB}};
                    carry_d = SUB ? 1'b1 : Cin;
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = s_next;
                carry_d = carry_out;
                count_d = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    cf_d    = carry_out;
                    // carry_q here is the carry into the MSB.
                    of_d    = carry_q ^ carry_out;
                    zf_d    = (s_next == '0);
                    nf_d    = sum_bit;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign S         = s_q;
    assign CF        = cf_q;
    assign OF        = of_q;

`ifdef SERIAL_ADD_SUB_STATUS_FLAGS_EN
    assign ZF = zf_q;
    assign NF = nf_q;
`else
    logic unused_flags;
    assign unused_flags = zf_q ^ nf_q;
`endif

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed self-checking bench for serial_adder_subtractor at DATA_WIDTH=4.
// Build with SERIAL_ADD_SUB_STATUS_FLAGS_EN defined to also check ZF/NF.
module tb_serial_adder_subtractor;

    localparam int unsigned DW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          Cin;
    logic          SUB;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] S;
    logic          CF;
    logic          OF;
`ifdef SERIAL_ADD_SUB_STATUS_FLAGS_EN
    logic          ZF;
    logic          NF;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 CLK = ~CLK;

    serial_adder_subtractor #(
        .DATA_WIDTH(DW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .SUB      (SUB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .CF       (CF),
        .OF       (OF)
`ifdef SERIAL_ADD_SUB_STATUS_FLAGS_EN
        ,
        .ZF       (ZF),
        .NF       (NF)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operand pair and return once out_valid is seen (or the bound expires).
    task automatic start_and_wait(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic cin, input logic sub);
        int lat;
        @(negedge CLK);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        SUB = sub;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, DW);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input logic sub, input logic [DW-1:0] exp_s,
                          input logic exp_cf, input logic exp_of);
        start_and_wait(tag, a, b, cin, sub);
        check({tag, "_S"}, S, exp_s);
        check({tag, "_CF"}, CF, exp_cf);
        check({tag, "_OF"}, OF, exp_of);
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_S_hold"}, S, exp_s);
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        SUB = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_CF", CF, 0);
        check("rst_OF", OF, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("t1", 4'b0001, 4'b0100, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
        run_op("t2a", 4'b1101, 4'b1100, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0);
        run_op("t2b", 4'b0101, 4'b0111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1);
        run_op("t3a", 4'b1000, 4'b1011, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
        run_op("t3b", 4'b0111, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);

        // Wrap to zero; flags checked while still in DONE.
        start_and_wait("t4", 4'b1111, 4'b0000, 1'b1, 1'b0);
        check("t4_S", S, 4'b0000);
        check("t4_CF", CF, 1);
        check("t4_OF", OF, 0);
`ifdef SERIAL_ADD_SUB_STATUS_FLAGS_EN
        check("t4_ZF", ZF, 1);
        check("t4_NF", NF, 0);
`endif
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;

        // Backpressure: DONE held 5 cycles while new operands are offered.
        start_and_wait("t5", 4'b0110, 4'b0011, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            A = 4'b1010;
            B = 4'b0101;
            SUB = 1'b0;
            @(posedge CLK);
            #1;
            check("t5_out_valid", out_valid, 1);
            check("t5_in_ready", in_ready, 0);
            check("t5_S", S, 4'b0011);
            check("t5_CF", CF, 1);
            check("t5_OF", OF, 0);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("t5_release_out_valid", out_valid, 0);
        check("t5_release_in_ready", in_ready, 1);
        check("t5_release_S", S, 4'b0011);

        // Reset mid-SHIFT, after two bits have been processed.
        @(negedge CLK);
        in_valid = 1'b1;
        A = 4'b0111;
        B = 4'b0111;
        Cin = 1'b0;
        SUB = 1'b0;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("t6_mid_in_ready", in_ready, 0);
        RST = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_S", S, 0);
        @(negedge CLK);
        RST = 1'b0;
        run_op("t6_next", 4'b0011, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
